// File: rtl/estagio_mem_wb.sv
// MEM/WB pipeline register with load extraction and writeback select.
// Optional define CONTADOR_RETIRADAS_EN adds the 'retiradas' retired-instruction counter.
module estagio_mem_wb #(
  parameter int unsigned LARGURA_DADOS = 32,
  parameter int unsigned LARGURA_REG   = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     in_valido,
  input  logic [LARGURA_DADOS-1:0] in_resultadoUla,
  input  logic [LARGURA_DADOS-1:0] in_dadoMemoria,
  input  logic [LARGURA_DADOS-1:0] in_pcMais4,
  input  logic [LARGURA_REG-1:0]   in_regDestino,
  input  logic                     in_escreverReg,
  input  logic [1:0]               in_selWb,
  input  logic [2:0]               in_tamanhoLoad,
  output logic                     wb_valido,
  output logic                     wb_escreverReg,
  output logic [LARGURA_REG-1:0]   wb_regDestino,
  output logic [LARGURA_DADOS-1:0] wb_dado,
  output logic                     wb_erroAlinhamento
`ifdef CONTADOR_RETIRADAS_EN
  ,
  output logic [31:0]              retiradas
`endif
);

  logic [1:0]               w_lane;
  logic [7:0]               w_byte;
  logic [15:0]              w_half;
  logic                     w_sinal;
  logic [LARGURA_DADOS-1:0] w_load;
  logic                     w_desalinhado;
  logic                     w_escrever;
  logic [LARGURA_DADOS-1:0] w_dado;

  logic                     r_valido;
  logic                     r_escreverReg;
  logic [LARGURA_REG-1:0]   r_regDestino;
  logic [LARGURA_DADOS-1:0] r_dado;
  logic                     r_erro;

  assign w_lane  = in_resultadoUla[1:0];
  assign w_sinal = ~in_tamanhoLoad[2];
  assign w_half  = w_lane[1] ? in_dadoMemoria[31:16] : in_dadoMemoria[15:0];

  always_comb begin
    w_byte = in_dadoMemoria[7:0];
    case (w_lane)
      2'd0:    w_byte = in_dadoMemoria[7:0];
      2'd1:    w_byte = in_dadoMemoria[15:8];
      2'd2:    w_byte = in_dadoMemoria[23:16];
      default: w_byte = in_dadoMemoria[31:24];
    endcase
  end

  always_comb begin
    w_load = in_dadoMemoria;
    case (in_tamanhoLoad[1:0])
      2'b00:   w_load = {{(LARGURA_DADOS-8){w_byte[7] & w_sinal}}, w_byte};
      2'b01:   w_load = {{(LARGURA_DADOS-16){w_half[15] & w_sinal}}, w_half};
      default: w_load = in_dadoMemoria;
    endcase
  end

  // Misalignment only matters for valid loads; bubbles never raise the error.
  assign w_desalinhado = in_valido && (in_selWb == 2'b01) &&
                         (((in_tamanhoLoad[1:0] == 2'b01) && w_lane[0]) ||
                          (in_tamanhoLoad[1] && (w_lane != 2'b00)));

  assign w_escrever = in_valido && in_escreverReg && (in_regDestino != '0) && !w_desalinhado;

  always_comb begin
    w_dado = in_resultadoUla;
    case (in_selWb)
      2'b01:   w_dado = w_desalinhado ? in_dadoMemoria : w_load;
      2'b10:   w_dado = in_pcMais4;
      default: w_dado = in_resultadoUla;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valido      <= 1'b0;
      r_escreverReg <= 1'b0;
      r_regDestino  <= '0;
      r_dado        <= '0;
      r_erro        <= 1'b0;
    end else if (flush) begin
      r_valido      <= 1'b0;
      r_escreverReg <= 1'b0;
      r_regDestino  <= '0;
      r_dado        <= '0;
      r_erro        <= 1'b0;
    end else if (!stall) begin
      r_valido      <= in_valido;
      r_escreverReg <= w_escrever;
      r_regDestino  <= in_regDestino;
      r_dado        <= w_dado;
      r_erro        <= w_desalinhado;
    end
  end

`ifdef CONTADOR_RETIRADAS_EN
  logic [31:0] r_retiradas;

  // Flush leaves the count untouched; wraps naturally at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_retiradas <= '0;
    end else if (!flush && !stall && in_valido && !w_desalinhado) begin
      r_retiradas <= r_retiradas + 32'd1;
    end
  end

  assign retiradas = r_retiradas;
`endif

  assign wb_valido          = r_valido;
  assign wb_escreverReg     = r_escreverReg;
  assign wb_regDestino      = r_regDestino;
  assign wb_dado            = r_dado;
  assign wb_erroAlinhamento = r_erro;

endmodule

// File: tb/tb_estagio_mem_wb.sv
// Randomized bench for estagio_mem_wb against a behavioural model, plus literal pins.
module tb_estagio_mem_wb;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valido = 1'b0;
  logic [31:0] in_resultadoUla = '0;
  logic [31:0] in_dadoMemoria = '0;
  logic [31:0] in_pcMais4 = '0;
  logic [4:0]  in_regDestino = '0;
  logic        in_escreverReg = 1'b0;
  logic [1:0]  in_selWb = '0;
  logic [2:0]  in_tamanhoLoad = '0;
  logic        wb_valido;
  logic        wb_escreverReg;
  logic [4:0]  wb_regDestino;
  logic [31:0] wb_dado;
  logic        wb_erroAlinhamento;
`ifdef CONTADOR_RETIRADAS_EN
  logic [31:0] retiradas;
`endif

  int checks = 0;
  int errors = 0;

  estagio_mem_wb dut (
    .clock              (clock),
    .reset              (reset),
    .stall              (stall),
    .flush              (flush),
    .in_valido          (in_valido),
    .in_resultadoUla    (in_resultadoUla),
    .in_dadoMemoria     (in_dadoMemoria),
    .in_pcMais4         (in_pcMais4),
    .in_regDestino      (in_regDestino),
    .in_escreverReg     (in_escreverReg),
    .in_selWb           (in_selWb),
    .in_tamanhoLoad     (in_tamanhoLoad),
    .wb_valido          (wb_valido),
    .wb_escreverReg     (wb_escreverReg),
    .wb_regDestino      (wb_regDestino),
    .wb_dado            (wb_dado),
    .wb_erroAlinhamento (wb_erroAlinhamento)
`ifdef CONTADOR_RETIRADAS_EN
    ,
    .retiradas          (retiradas)
`endif
  );

  always #5 clock = ~clock;

  // Behavioural model: arithmetic shifts/masks on the spec's rules.
  function automatic logic [31:0] extrai(input logic [31:0] mem, input int lane,
                                         input logic [2:0] tam);
    logic [31:0] v;
    if (tam[1:0] == 2'b00) begin
      v = (mem >> (8 * lane)) & 32'hFF;
      if (!tam[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (tam[1:0] == 2'b01) begin
      v = (mem >> (16 * (lane / 2))) & 32'hFFFF;
      if (!tam[2] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = mem;
    end
    return v;
  endfunction

  function automatic logic desalinhado(input logic val, input logic [1:0] sel, input int lane,
                                       input logic [2:0] tam);
    if (!val || sel != 2'b01) return 1'b0;
    if (tam[1:0] == 2'b01) return (lane % 2) == 1;
    if (tam[1]) return lane != 0;
    return 1'b0;
  endfunction

  logic        e_valido, e_esc, e_erro;
  logic [4:0]  e_rd;
  logic [31:0] e_dado, e_ret;

  always @(posedge clock or posedge reset) begin
    int lane;
    logic mis;
    lane = int'(in_resultadoUla % 4);
    mis  = desalinhado(in_valido, in_selWb, lane, in_tamanhoLoad);
    if (reset) begin
      e_valido <= 0; e_esc <= 0; e_erro <= 0; e_rd <= 0; e_dado <= 0; e_ret <= 0;
    end else if (flush) begin
      e_valido <= 0; e_esc <= 0; e_erro <= 0; e_rd <= 0; e_dado <= 0;
    end else if (!stall) begin
      e_valido <= in_valido;
      e_esc    <= in_valido && in_escreverReg && (in_regDestino != 0) && !mis;
      e_erro   <= mis;
      e_rd     <= in_regDestino;
      if (in_selWb == 2'b10) e_dado <= in_pcMais4;
      else if (in_selWb == 2'b01) e_dado <= mis ? in_dadoMemoria
                                                : extrai(in_dadoMemoria, lane, in_tamanhoLoad);
      else e_dado <= in_resultadoUla;
      if (in_valido && !mis) e_ret <= e_ret + 1;
    end
  end

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", nome, act, exp, $time);
    end
  endtask

  task automatic comparar();
    chk("valido", {31'b0, wb_valido}, {31'b0, e_valido});
    chk("escreverReg", {31'b0, wb_escreverReg}, {31'b0, e_esc});
    chk("regDestino", {27'b0, wb_regDestino}, {27'b0, e_rd});
    chk("dado", wb_dado, e_dado);
    chk("erroAlinhamento", {31'b0, wb_erroAlinhamento}, {31'b0, e_erro});
`ifdef CONTADOR_RETIRADAS_EN
    chk("retiradas", retiradas, e_ret);
`endif
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    comparar();
  endtask

  task automatic poe(input logic v, input logic [31:0] alu, input logic [31:0] mem,
                     input logic [31:0] pc, input logic [4:0] rd, input logic esc,
                     input logic [1:0] sel, input logic [2:0] tam,
                     input logic st, input logic fl);
    in_valido = v; in_resultadoUla = alu; in_dadoMemoria = mem; in_pcMais4 = pc;
    in_regDestino = rd; in_escreverReg = esc; in_selWb = sel; in_tamanhoLoad = tam;
    stall = st; flush = fl;
  endtask

  task automatic aleatorio();
    poe(1'($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom,
        5'($urandom_range(0, 31)), 1'($urandom), 2'($urandom), 3'($urandom),
        1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 15) == 0));
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    comparar();
    chk("reset_dado", wb_dado, 32'h0);
    reset = 1'b0;

    // 4 retires, a stall, a flush, a misaligned load
    for (int i = 1; i <= 4; i++) begin
      poe(1, 32'h100 + i, 0, 0, 5'(i), 1, 2'b00, 3'b000, 0, 0);
      tick();
    end
    poe(1, 32'h200, 0, 0, 5'd7, 1, 2'b00, 3'b000, 1, 0); tick();
    poe(1, 32'h300, 0, 0, 5'd7, 1, 2'b00, 3'b000, 0, 1); tick();
    chk("flush_valido", {31'b0, wb_valido}, 32'h0);
    poe(1, 32'h401, 32'hCAFE_F00D, 0, 5'd8, 1, 2'b01, 3'b010, 0, 0); tick();
    chk("mis_word_erro", {31'b0, wb_erroAlinhamento}, 32'h1);
    chk("mis_word_dado", wb_dado, 32'hCAFE_F00D);
`ifdef CONTADOR_RETIRADAS_EN
    chk("retiradas_4", retiradas, 32'd4);
`endif

    poe(1, 32'h0000_0102, 32'h1280_3456, 0, 5'd5, 1, 2'b01, 3'b000, 0, 0); tick();
    chk("lb_dado", wb_dado, 32'hFFFF_FF80);
    chk("lb_esc", {31'b0, wb_escreverReg}, 32'h1);
    chk("lb_rd", {27'b0, wb_regDestino}, 32'd5);
    poe(1, 32'h0000_0102, 32'h1280_3456, 0, 5'd5, 1, 2'b01, 3'b100, 0, 0); tick();
    chk("lbu_dado", wb_dado, 32'h0000_0080);
    poe(1, 32'h0000_0002, 32'h8001_1234, 0, 5'd6, 1, 2'b01, 3'b001, 0, 0); tick();
    chk("lh_dado", wb_dado, 32'hFFFF_8001);
    poe(1, 32'h0000_0001, 32'h8001_1234, 0, 5'd6, 1, 2'b01, 3'b001, 0, 0); tick();
    chk("lh_mis_erro", {31'b0, wb_erroAlinhamento}, 32'h1);
    chk("lh_mis_esc", {31'b0, wb_escreverReg}, 32'h0);
    poe(1, 32'h1234_5678, 0, 32'h0000_0040, 5'd9, 1, 2'b11, 3'b000, 0, 0); tick();
    chk("sel11_dado", wb_dado, 32'h1234_5678);
    poe(1, 32'hDEAD_BEEF, 0, 32'h0000_0040, 5'd0, 1, 2'b00, 3'b000, 0, 0); tick();
    chk("x0_esc", {31'b0, wb_escreverReg}, 32'h0);
    poe(1, 32'h1111_1111, 0, 32'h0000_0040, 5'd10, 1, 2'b10, 3'b000, 0, 0); tick();
    chk("pc4_dado", wb_dado, 32'h0000_0040);
    for (int i = 0; i < 3; i++) begin
      poe(1, $urandom, $urandom, $urandom, 5'd11, 1, 2'b00, 3'b000, 1, 0); tick();
      chk("stall_dado", wb_dado, 32'h0000_0040);
      chk("stall_rd", {27'b0, wb_regDestino}, 32'd10);
    end
    poe(1, 32'h5, 0, 0, 5'd12, 1, 2'b00, 3'b000, 1, 1); tick();
    chk("stallflush_valido", {31'b0, wb_valido}, 32'h0);
    chk("stallflush_esc", {31'b0, wb_escreverReg}, 32'h0);

    for (int n = 0; n < 400; n++) begin
      aleatorio();
      if (n == 200) begin
        poe(1, 32'h77, 0, 0, 5'd3, 1, 2'b00, 3'b000, 0, 0);
        tick();
        #2 reset = 1'b1;
        #1;
        chk("rst_valido", {31'b0, wb_valido}, 32'h0);
        chk("rst_esc", {31'b0, wb_escreverReg}, 32'h0);
        chk("rst_dado", wb_dado, 32'h0);
        @(negedge clock);
        comparar();
        reset = 1'b0;
        poe(1, 32'h99, 0, 0, 5'd4, 1, 2'b00, 3'b000, 0, 0);
        tick();
        chk("pos_rst_dado", wb_dado, 32'h99);
      end else begin
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
